// File: rtl/fifo_pkg.sv
// Shared encodings and sizes for the 16-entry FIFO control path.
// Imported by fifo_ctrl_16, fifo_ns_16 and the output-flag decoder.
package fifo_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT   = 3'b000;
  localparam state_t ST_NO_OP  = 3'b001;
  localparam state_t ST_WRITE  = 3'b010;
  localparam state_t ST_WR_ERR = 3'b011;
  localparam state_t ST_READ   = 3'b100;
  localparam state_t ST_RD_ERR = 3'b101;

endpackage

// File: rtl/fifo_ns_16.sv
// Next-state logic for the FIFO control core: state, count,
// pointer advances and storage strobes from request + occupancy.
module fifo_ns_16
  import fifo_pkg::*;
(
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] data_count,
  output state_t        state_d,
  output logic [CW-1:0] count_d,
  output logic          wr_inc,
  output logic          rd_inc,
  output logic          we,
  output logic          re
);

  logic full;
  logic empty;

  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);

  // simultaneous requests fall through to NO_OP
  always_comb begin
    state_d = ST_NO_OP;
    count_d = data_count;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    unique case ({wr_en, rd_en})
      2'b10: begin
        if (full) begin
          state_d = ST_WR_ERR;
        end else begin
          state_d = ST_WRITE;
          count_d = data_count + CW'(1);
          wr_inc  = 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          state_d = ST_RD_ERR;
        end else begin
          state_d = ST_READ;
          count_d = data_count - CW'(1);
          rd_inc  = 1'b1;
        end
      end
      default: begin
        state_d = ST_NO_OP;
      end
    endcase
  end

  assign we = wr_inc;
  assign re = rd_inc;

endmodule

// File: rtl/fifo_ctrl_16.sv
// Register core of the 16-entry FIFO controller.
// Optional high-water mark output enabled by FIFO_CTRL_PEAK_EN.
module fifo_ctrl_16
  import fifo_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [2:0]    state,
  output logic [CW-1:0] data_count,
  output logic          we,
  output logic          re,
`ifdef FIFO_CTRL_PEAK_EN
  output logic [CW-1:0] peak_count,
`endif
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr
);

  state_t        state_q, state_d, ns_state;
  logic [CW-1:0] count_q, count_d, ns_count;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          wr_inc, rd_inc;

  fifo_ns_16 u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_count (count_q),
    .state_d    (ns_state),
    .count_d    (ns_count),
    .wr_inc     (wr_inc),
    .rd_inc     (rd_inc),
    .we         (we),
    .re         (re)
  );

  always_comb begin
    state_d = ns_state;
    count_d = ns_count;
    wptr_d  = wptr_q + AW'(wr_inc);
    rptr_d  = rptr_q + AW'(rd_inc);
    if (reset) begin
      state_d = ST_INIT;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    count_q <= count_d;
    wptr_q  <= wptr_d;
    rptr_q  <= rptr_d;
  end

`ifdef FIFO_CTRL_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // tracks next count so the peak lands in the same cycle
  always_comb begin
    peak_d = (count_d > peak_q) ? count_d : peak_q;
    if (reset) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

  assign state      = state_q;
  assign data_count = count_q;
  assign wr_addr    = wptr_q;
  assign rd_addr    = rptr_q;

endmodule

// File: tb/tb_fifo_ctrl_16.sv
// Self-checking bench for fifo_ctrl_16: directed steps then random
// traffic against a queue-based reference model.
module tb_fifo_ctrl_16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  logic [4:0] data_count;
  logic       we;
  logic       re;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
`ifdef FIFO_CTRL_PEAK_EN
  logic [4:0] peak_count;
`endif

  always #5 clk = ~clk;

  fifo_ctrl_16 dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .state      (state),
    .data_count (data_count),
    .we         (we),
    .re         (re),
`ifdef FIFO_CTRL_PEAK_EN
    .peak_count (peak_count),
`endif
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference model: occupancy is the size of a token queue
  int   q[$];
  int   n_wr   = 0;
  int   n_rd   = 0;
  int   m_peak = 0;
  int   m_st   = 0;
  bit   known  = 1'b0;
  int   tok    = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit w, input bit r);
    int  cnt;
    bit  e_we, e_re;
    cnt   = q.size();
    reset = rst;
    wr_en = w;
    rd_en = r;
    #1;
    e_we = w && !r && cnt < 16;
    e_re = r && !w && cnt > 0;
    if (known) begin
      chk("we", {31'd0, we}, {31'd0, e_we});
      chk("re", {31'd0, re}, {31'd0, e_re});
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      n_wr = 0; n_rd = 0; m_peak = 0; m_st = 0;
      known = 1'b1;
    end else if (w && !r) begin
      if (cnt == 16) m_st = 3;
      else begin
        m_st = 2; q.push_back(tok++); n_wr++;
      end
    end else if (r && !w) begin
      if (cnt == 0) m_st = 5;
      else begin
        m_st = 4; void'(q.pop_front()); n_rd++;
      end
    end else begin
      m_st = 1;
    end
    if (q.size() > m_peak) m_peak = q.size();
    #1;
    if (known) begin
      chk("state", {29'd0, state}, m_st);
      chk("data_count", {27'd0, data_count}, q.size());
      chk("wr_addr", {28'd0, wr_addr}, n_wr % 16);
      chk("rd_addr", {28'd0, rd_addr}, n_rd % 16);
`ifdef FIFO_CTRL_PEAK_EN
      chk("peak_count", {27'd0, peak_count}, m_peak);
`endif
    end
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;

    // reset with a write pending
    step(1, 1, 0);
    chk("reset_state", {29'd0, state}, 0);

    // fill past full
    for (int i = 0; i < 17; i++) step(0, 1, 0);
    chk("full_wrerr", {29'd0, state}, 3);
    chk("full_cnt", {27'd0, data_count}, 16);
    chk("full_wrap", {28'd0, wr_addr}, 0);

    // drain past empty
    for (int i = 0; i < 17; i++) step(0, 0, 1);
    chk("empty_rderr", {29'd0, state}, 5);
    chk("empty_cnt", {27'd0, data_count}, 0);

    // simultaneous at count 5
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("simul_state", {29'd0, state}, 1);
    chk("simul_cnt", {27'd0, data_count}, 5);

    // mid-op reset at count 9
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0);
    step(1, 1, 0);
    chk("midrst_cnt", {27'd0, data_count}, 0);
    step(0, 1, 0);
    chk("post_rst_wr", {29'd0, state}, 2);

    // high-water scenario
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    chk("peak_cnt6", {27'd0, data_count}, 6);

    // random traffic, phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 60) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < bias,
           $urandom_range(0, 99) < (100 - bias));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
